// File: rtl/vec_relu_grad_if.sv
// Handshake bundle for vec_relu_grad: forward-mask push, gradient pop and masked-gradient output.
interface vec_relu_grad_if #(
  parameter int unsigned VEC_SIZE   = 4,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned MASK_DEPTH = 8
);
  localparam int unsigned W      = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned DATA_W = VEC_SIZE * W;
  localparam int unsigned CNT_W  = $clog2(MASK_DEPTH + 1);

  logic              flush;
  logic              fwd_valid;
  logic              fwd_ready;
  logic [DATA_W-1:0] fwd_in;
  logic              grad_valid;
  logic              grad_ready;
  logic [DATA_W-1:0] grad_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  mask_count;

  modport master (
    output flush, fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
    input  fwd_ready, grad_ready, out_valid, out_data, mask_count
  );

  modport slave (
    input  flush, fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
    output fwd_ready, grad_ready, out_valid, out_data, mask_count
  );
endinterface

// File: rtl/vec_relu_grad.sv
// ReLU backward gate: queues per-element "was positive" masks from the forward stream
// and applies them, in arrival order, to incoming gradient vectors.
module vec_relu_grad #(
  parameter int unsigned VEC_SIZE   = 4,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned FRAC_WIDTH = 23,
  parameter int unsigned MASK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  vec_relu_grad_if.slave bus
);
  localparam int unsigned W      = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned DATA_W = VEC_SIZE * W;
  localparam int unsigned PTR_W  = $clog2(MASK_DEPTH);
  localparam int unsigned CNT_W  = $clog2(MASK_DEPTH + 1);

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [VEC_SIZE-1:0] mask_mem [MASK_DEPTH];

  logic [VEC_SIZE-1:0] fwd_mask_c;
  logic [VEC_SIZE-1:0] rd_mask_c;
  logic [DATA_W-1:0]   gated_c;
  logic                fwd_ready_c;
  logic                grad_ready_c;
  logic                push_c;
  logic                pop_c;

  // Readiness depends only on registered state, flush and out_ready.
  assign fwd_ready_c  = (count_q < CNT_W'(MASK_DEPTH)) && !bus.flush;
  assign grad_ready_c = (count_q != '0) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign push_c       = bus.fwd_valid && fwd_ready_c;
  assign pop_c        = bus.grad_valid && grad_ready_c;
  assign rd_mask_c    = mask_mem[rd_ptr];

  // Strictly positive: sign clear and magnitude non-zero (+NaN/+Inf count as positive).
  always_comb begin
    fwd_mask_c = '0;
    for (int i = 0; i < int'(VEC_SIZE); i++) begin
      fwd_mask_c[i] = !bus.fwd_in[i*W + W - 1] && (|bus.fwd_in[i*W +: W-1]);
    end
  end

  // Masked-off elements become +0.
  always_comb begin
    gated_c = '0;
    for (int i = 0; i < int'(VEC_SIZE); i++) begin
      if (rd_mask_c[i]) gated_c[i*W +: W] = bus.grad_in[i*W +: W];
    end
  end

  // Mask storage needs no reset: entries are only read while counted as held.
  always_ff @(posedge clk) begin
    if (push_c) mask_mem[wr_ptr] <= fwd_mask_c;
  end

  // Pointers and occupancy; full/empty come from count_q alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (pop_c && !push_c) count_q <= count_q - CNT_W'(1);
    end
  end

  // Output register: load on pop, release on accept, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pop_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= gated_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.fwd_ready  = fwd_ready_c;
  assign bus.grad_ready = grad_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.mask_count = count_q;

endmodule

// File: doc/vec_relu_grad.md
# vec_relu_grad

Backward-pass companion to the vector ReLU stage. It records a per-element "was positive" mask for each forward vector in a small FIFO. Later, it gates incoming gradient vectors with those masks in arrival order. The output is grad·ReLU′(x): each element passes through where the forward input was strictly positive and becomes +0 elsewhere. It sits between the forward activation stream and the backward gradient stream, with valid/ready handshakes on all three ports.

## Interface
- VEC_SIZE, 4, elements per vector
- EXP_WIDTH, 8, float exponent bits
- FRAC_WIDTH, 23, float fraction bits; element width W = 1+EXP_WIDTH+FRAC_WIDTH; element i occupies bits [i*W +: W]
- MASK_DEPTH, 8, mask FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of mask FIFO
- fwd_valid  in  1  forward vector valid
- fwd_ready  out  1  mask FIFO can accept
- fwd_in  in  VEC_SIZE*W  forward-pass ReLU input vector
- grad_valid  in  1  gradient vector valid
- grad_ready  out  1  gradient accepted this cycle when high with grad_valid
- grad_in  in  VEC_SIZE*W  upstream gradient vector
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  VEC_SIZE*W  masked gradient, registered
- mask_count  out  $clog2(MASK_DEPTH+1)  entries currently held

## Operation
- Mask bit i = 1 iff sign bit of element i is 0 and exponent/fraction are not all zero. +0 and every negative value (including -0) give 0. Positive NaN/Inf give 1.
- Push: fwd_valid && fwd_ready writes the VEC_SIZE-bit mask at wr_ptr, and wr_ptr increments modulo MASK_DEPTH.
- fwd_ready = (mask_count < MASK_DEPTH) && !flush. It is combinational from registered state and flush only.
- Pop: grad_valid && grad_ready reads the mask at rd_ptr and rd_ptr increments modulo MASK_DEPTH. In the same edge, out_data element i is loaded with mask[i] ? grad_in element i : all-zero, and out_valid is set to 1.
- grad_ready = (mask_count != 0) && (!out_valid || out_ready) && !flush. There is no bypass: a mask pushed in cycle N is poppable from cycle N+1.
- Output register:
  - out_valid clears on out_valid && out_ready when there is no pop that cycle.
  - out_data holds stable while out_valid && !out_ready.
- Simultaneous push and pop: mask_count is unchanged and both pointers advance. This is legal at full only if fwd_ready was high, so it never occurs at full.
- flush: wr_ptr, rd_ptr and mask_count are cleared to 0 at the edge. Push and pop are blocked that cycle. out_valid/out_data are unaffected.
- Pointer wrap: pointers are $clog2(MASK_DEPTH) bits and wrap naturally. Full/empty are decided by mask_count only.

## Timing
- Reset (async assert, sync deassert by the environment):
  - out_valid=0, out_data=0, mask_count=0, pointers=0.
  - Immediately after reset, fwd_ready=1 and grad_ready=0.
- Latency grad_in→out_data: 1 cycle. Throughput: 1 vector/cycle when out_ready is held high and masks are available.
- Reset asserted mid-transfer: all state clears immediately, and in-flight masks and the output are discarded.
- Handshake inputs obey standard rules: valid is not withdrawn and data is held until ready. The block does not check this.
- fwd_ready and grad_ready do not depend combinationally on fwd_valid/grad_valid. grad_ready does depend combinationally on out_ready.

## Test plan
- Mask encoding:
  - Stimulus: reset, then push fwd_in = {el0 0x3F800000, el1 0xC0000000, el2 0x00000000, el3 0x80000000}, then grad_in = 4×0x40400000.
  - Required: next cycle out_valid=1, out_data = {0x40400000, 0, 0, 0}, mask_count returns 1→0.
- Fill/full:
  - Stimulus: push 8 vectors with grad_valid=0.
  - Required: mask_count=8, fwd_ready=0 on the 9th cycle, and the 9th vector is not accepted.
  - Then pop one: fwd_ready=1 the following cycle.
- Order and wrap:
  - Stimulus: push 12 and pop 12, interleaved, with distinct masks (e.g. mask k = k mod 16 via sign patterns), out_ready=1.
  - Required: outputs match masks in push order across the pointer wrap, with no gaps at 1/cycle.
- Backpressure:
  - Stimulus: out_ready=0 with 2 masks queued and grad_valid=1.
  - Required: exactly one pop, then grad_ready=0 and out_data stable.
  - Then out_ready=1: second pop in the same cycle as the first output is accepted.
- Empty:
  - Stimulus: grad_valid=1 with mask_count=0.
  - Required: grad_ready=0 and out_valid stays 0.
  - Push one mask: grad_ready=1 from the next cycle.
- Flush/reset:
  - Stimulus: 3 masks queued, assert flush together with fwd_valid.
  - Required: mask_count=0 next cycle, the push is dropped, and a pending out_valid is retained.
  - Assert rst_n=0 mid-stream: out_valid=0 and mask_count=0 immediately, without waiting for a clock edge.
